// File: rtl/pb_pkg.sv
// Shared constants and helpers for the push-button input conditioner.
// Provides default channel count, synchroniser depth, tick divider and
// qualification length, plus the counter-width helper used by all blocks.
package pb_pkg;

  localparam int unsigned PB_WIDTH        = 8;
  localparam int unsigned PB_SYNC_STAGES  = 2;
  localparam int unsigned PB_TICK_DIV     = 1000;
  localparam int unsigned PB_STABLE_TICKS = 4;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int unsigned pb_cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pb_debounce_chan.sv
// One conditioner channel: pad synchroniser, tick-based debounce counter and
// the debounced level flop.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   tick_i      - shared prescaler tick
//   raw_i       - asynchronous pad input
//   level_o     - debounced level (registered)
//   rise_o      - one-cycle pulse on a debounced 0->1 flip (registered)
//   flip_c      - level will toggle at the coming edge (combinational)
//   rise_c      - level will rise at the coming edge (combinational)
module pb_debounce_chan
  import pb_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = PB_SYNC_STAGES,
  parameter int unsigned STABLE_TICKS = PB_STABLE_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic flip_c,
  output logic rise_c
);

  localparam int unsigned CNT_W = pb_cnt_width(STABLE_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   rise_q, rise_d;
  logic                   sync;

  assign sync = sync_q[SYNC_STAGES-1];

  // Any agreement restarts qualification; a flip needs STABLE_TICKS
  // consecutive ticks of disagreement.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], raw_i};
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync == stable_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    rise_d = stable_d & ~stable_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
    end
  end

  assign level_o = stable_q;
  assign rise_o  = rise_q;
  assign flip_c  = stable_d ^ stable_q;
  assign rise_c  = rise_d;

endmodule

// File: rtl/pb_input_conditioner.sv
// Multi-channel push-button/switch conditioner feeding the priority encoder.
// Synchronises and debounces each pad input against a shared prescaled tick
// and presents a clean level vector, per-channel rise pulses and a change
// strobe.
// Build option: define PB_LATCH_EN to make data_out sticky (set by a rise,
// cleared by clear); otherwise data_out follows the debounced level and
// clear is ignored.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   raw_in      - unsynchronised pad inputs, active high
//   clear       - sticky-latch clear (PB_LATCH_EN builds only)
//   data_out    - conditioned level vector
//   rise_pulse  - one-cycle pulse per debounced 0->1 transition
//   changed     - one-cycle strobe on any data_out change
module pb_input_conditioner
  import pb_pkg::*;
#(
  parameter int unsigned WIDTH        = PB_WIDTH,
  parameter int unsigned SYNC_STAGES  = PB_SYNC_STAGES,
  parameter int unsigned TICK_DIV     = PB_TICK_DIV,
  parameter int unsigned STABLE_TICKS = PB_STABLE_TICKS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_in,
  input  logic             clear,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic             changed
);

  localparam int unsigned PRE_W = pb_cnt_width(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] rise_vec;
  logic [WIDTH-1:0] flip;
  logic [WIDTH-1:0] rise_nxt;
  logic             changed_q, changed_d;

  // Free-running prescaler shared by all channels.
  assign tick = (pre_q == PRE_LAST);

  always_comb begin
    pre_d = tick ? '0 : pre_q + PRE_W'(1);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    pb_debounce_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .STABLE_TICKS(STABLE_TICKS)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick_i (tick),
      .raw_i  (raw_in[i]),
      .level_o(level[i]),
      .rise_o (rise_vec[i]),
      .flip_c (flip[i]),
      .rise_c (rise_nxt[i])
    );
  end

`ifdef PB_LATCH_EN
  logic [WIDTH-1:0] latch_q, latch_d;
  logic [WIDTH-1:0] unused_level;

  assign unused_level = level ^ flip;

  // Set beats clear both at the flip edge and while the rise pulse is shown.
  always_comb begin
    latch_d   = (latch_q & ~{WIDTH{clear}}) | rise_nxt | rise_vec;
    changed_d = |(latch_d ^ latch_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_q <= '0;
    end else begin
      latch_q <= latch_d;
    end
  end

  assign data_out = latch_q;
`else
  logic unused_clear;
  logic [WIDTH-1:0] unused_rise_nxt;

  assign unused_clear    = clear;
  assign unused_rise_nxt = rise_nxt;

  always_comb begin
    changed_d = |flip;
  end

  assign data_out = level;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q     <= '0;
      changed_q <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      changed_q <= changed_d;
    end
  end

  assign rise_pulse = rise_vec;
  assign changed    = changed_q;

endmodule

// File: tb/tb_pb_input_conditioner.sv
// Scoreboard bench for pb_input_conditioner: a cycle-indexed reference model
// pushes expected output events, a negedge monitor pops and compares them.
module tb_pb_input_conditioner;

  localparam int unsigned W  = 8;
  localparam int unsigned SS = 2;
  localparam int unsigned TD = 4;
  localparam int unsigned ST = 3;

  logic         clk    = 1'b0;
  logic         rst_n  = 1'b0;
  logic         clear  = 1'b0;
  logic [W-1:0] raw_in = '0;
  logic [W-1:0] data_out;
  logic [W-1:0] rise_pulse;
  logic         changed;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct {
    int unsigned  cyc;
    logic [W-1:0] data;
    logic [W-1:0] rise;
    logic         chg;
  } ev_t;

  ev_t          exp_q[$];
  int unsigned  cyc = 0;
  logic [W-1:0] m_lvl = '0;
  logic [W-1:0] m_out = '0;
  logic [W-1:0] m_rise_prev = '0;
  logic [W-1:0] m_hist [SS];
  int unsigned  m_tk [W];

  pb_input_conditioner #(
    .WIDTH       (W),
    .SYNC_STAGES (SS),
    .TICK_DIV    (TD),
    .STABLE_TICKS(ST)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_in    (raw_in),
    .clear     (clear),
    .data_out  (data_out),
    .rise_pulse(rise_pulse),
    .changed   (changed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: sync = raw delayed SS edges, tick on every TD-th edge since
  // reset, a channel adopts sync after ST ticks of unbroken disagreement.
  task automatic model_step();
    logic [W-1:0] syn, lvl_n, rise, out_n;
    bit tick;
    ev_t e;
    syn   = m_hist[SS-1];
    tick  = ((cyc % TD) == TD - 1);
    lvl_n = m_lvl;
    for (int i = 0; i < W; i++) begin
      if (syn[i] == m_lvl[i]) begin
        m_tk[i] = 0;
      end else if (tick) begin
        m_tk[i] = m_tk[i] + 1;
        if (m_tk[i] == ST) begin
          lvl_n[i] = syn[i];
          m_tk[i]  = 0;
        end
      end
    end
    rise = lvl_n & ~m_lvl;
`ifdef PB_LATCH_EN
    out_n = (m_out & ~{W{clear}}) | rise | m_rise_prev;
`else
    out_n = lvl_n;
`endif
    for (int s = SS - 1; s > 0; s--) m_hist[s] = m_hist[s-1];
    m_hist[0] = raw_in;
    cyc = cyc + 1;
    if (out_n != m_out || rise != '0) begin
      e.cyc  = cyc;
      e.data = out_n;
      e.rise = rise;
      e.chg  = (out_n != m_out);
      exp_q.push_back(e);
    end
    m_lvl       = lvl_n;
    m_out       = out_n;
    m_rise_prev = rise;
  endtask

  initial begin
    for (int i = 0; i < SS; i++) m_hist[i] = '0;
    for (int i = 0; i < W; i++) m_tk[i] = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        for (int i = 0; i < SS; i++) m_hist[i] = '0;
        for (int i = 0; i < W; i++) m_tk[i] = 0;
        m_lvl       = '0;
        m_out       = '0;
        m_rise_prev = '0;
        cyc         = 0;
        exp_q.delete();
      end else begin
        model_step();
      end
    end
  end

  // Monitor: fires whenever the DUT presents a strobe or rise pulse.
  initial begin
    bit  exp_fire;
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        exp_fire = (exp_q.size() != 0) && (exp_q[0].cyc == cyc);
        chk("evt_present", 32'(changed || (rise_pulse != '0)), 32'(exp_fire));
        if (exp_fire) begin
          e = exp_q.pop_front();
          chk("evt_data", 32'(data_out), 32'(e.data));
          chk("evt_rise", 32'(rise_pulse), 32'(e.rise));
          chk("evt_changed", 32'(changed), 32'(e.chg));
        end
        chk("level_track", 32'(data_out), 32'(m_out));
      end
    end
  end

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a new vector, wait for data_out to move, check latency and strobes.
  task automatic press(input string nm, input logic [W-1:0] v, input logic [W-1:0] er);
    logic [W-1:0] prev;
    int unsigned  n0, lat;
    bit           seen;
    @(posedge clk); #1;
    prev   = data_out;
    raw_in = v;
    n0     = cyc;
    seen   = 0;
    lat    = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk); #1;
      if (data_out !== prev) begin
        seen = 1;
        lat  = cyc - n0;
      end
    end
    chk({nm, "_data"}, 32'(data_out), 32'(v));
    chk({nm, "_lat"}, 32'(seen && lat >= 11 && lat <= 14), 32'(1));
    chk({nm, "_rise"}, 32'(rise_pulse), 32'(er));
    chk({nm, "_chg"}, 32'(changed), 32'(1));
    @(posedge clk); #1;
    chk({nm, "_rise_1cyc"}, 32'(rise_pulse), 32'(0));
    chk({nm, "_chg_1cyc"}, 32'(changed), 32'(0));
    chk({nm, "_data_hold"}, 32'(data_out), 32'(v));
  endtask

`ifdef PB_LATCH_EN
  task automatic do_clear(input string nm);
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk({nm, "_data"}, 32'(data_out), 32'(0));
    chk({nm, "_chg"}, 32'(changed), 32'(1));
  endtask
`endif

  initial begin
    int unsigned lat, n0, bhi;
    bit          seen;

    // Reset with all pads pressed.
    rst_n  = 1'b0;
    raw_in = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", 32'(data_out), 32'(0));
    chk("rst_rise", 32'(rise_pulse), 32'(0));
    chk("rst_chg", 32'(changed), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    lat   = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk); #1;
      if (data_out == '1) begin
        seen = 1;
        lat  = cyc;
      end
    end
    chk("rst_lat", 32'(seen && lat >= 11 && lat <= 14), 32'(1));
    chk("rst_rise_ff", 32'(rise_pulse), 32'(8'hFF));

`ifdef PB_LATCH_EN
    @(posedge clk); #1;
    raw_in = '0;
    settle(20);
    chk("latch_hold_ff", 32'(data_out), 32'(8'hFF));
    do_clear("clr_ff");
    press("press04", 8'h04, 8'h04);
    raw_in = '0;
    settle(20);
    chk("latch_hold_04", 32'(data_out), 32'(8'h04));
    do_clear("clr_04");
    @(posedge clk); #1;
    raw_in = 8'h20;
    seen   = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk); #1;
      if (rise_pulse[5]) seen = 1;
    end
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("set_wins_seen", 32'(seen), 32'(1));
    chk("set_wins_bit5", 32'(data_out[5]), 32'(1));
    raw_in = '0;
    settle(20);
    do_clear("clr_20");
`else
    press("all_rel", 8'h00, 8'h00);
    press("press10", 8'h10, 8'h10);
    press("rel10", 8'h00, 8'h00);
    press("simul81", 8'h81, 8'h81);
    press("rel81", 8'h00, 8'h00);
    press("press04", 8'h04, 8'h04);
    press("rel04", 8'h00, 8'h00);
`endif

    // Bounce on bit 3: 5-clock segments never qualify.
    bhi = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      raw_in[3] = ((i % 2) == 0);
      if (data_out[3]) bhi++;
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        if (data_out[3]) bhi++;
      end
    end
    @(posedge clk); #1;
    raw_in[3] = 1'b1;
    n0   = cyc;
    seen = 0;
    lat  = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk); #1;
      if (data_out[3]) begin
        seen = 1;
        lat  = cyc - n0;
      end
    end
    chk("bounce_quiet", bhi, 0);
    chk("bounce_lat", 32'(seen && lat >= 11 && lat <= 14), 32'(1));

    // Random pad activity with mixed hold lengths and clear pulses.
    for (int it = 0; it < 200; it++) begin
      @(posedge clk); #1;
      raw_in = raw_in ^ 8'($urandom_range(0, 255));
      clear  = ($urandom_range(0, 7) == 0);
      repeat ($urandom_range(0, 16)) @(posedge clk);
    end
    @(posedge clk); #1;
    clear = 1'b0;
    settle(40);
    @(negedge clk); #1;
    chk("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pb_input_conditioner.md
Name: pb_input_conditioner

Overview:
- 8-channel push-button/switch conditioner directly upstream of the priority-encoder-to-7-segment stage.
- Synchronises asynchronous pad inputs, debounces each channel against a shared prescaled tick, and presents a clean, glitch-free vector to the encoder's data input.
- Also emits per-channel rising-edge pulses and a one-cycle change strobe for downstream sequential logic.

Parameters:
- WIDTH, 8, number of input channels.
- SYNC_STAGES, 2, flip-flop depth of the per-channel synchroniser; legal values are 2 or more.
- TICK_DIV, 1000, clocks per debounce tick; legal values are 1 or more; a value of 1 gives a tick every cycle.
- STABLE_TICKS, 4, consecutive ticks of disagreement required before a channel flips; legal values are 1 or more.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- raw_in  in  WIDTH  unsynchronised pad inputs, active high.
- clear  in  1  sticky-latch clear; used only when PB_LATCH_EN is defined, otherwise ignored.
- data_out  out  WIDTH  debounced level vector; feeds the encoder data input.
- rise_pulse  out  WIDTH  one-cycle pulse per channel on a debounced 0->1 transition.
- changed  out  1  one-cycle strobe when any data_out bit changes.

Behaviour:
- Reset is asynchronous and active-low on all flops. While rst_n=0:
  - all synchroniser flops, prescaler, per-channel counters, data_out, rise_pulse and changed are 0.
- Synchroniser:
  - raw_in[i] passes through SYNC_STAGES flops; the last stage is sync[i].
  - A change on raw_in appears on sync exactly SYNC_STAGES clocks later.
- Prescaler:
  - Counter runs 0..TICK_DIV-1 and wraps.
  - tick=1 for exactly the cycle in which the counter equals TICK_DIV-1.
  - Free-running, shared by all channels, never reset except by rst_n.
- Per-channel debounce (stable[i] drives data_out[i]):
  - If sync[i]==stable[i]: counter cnt[i] is cleared to 0 on that cycle, regardless of tick.
  - If sync[i]!=stable[i] and tick=1:
    - if cnt[i]==STABLE_TICKS-1, then stable[i]<=sync[i] and cnt[i]<=0;
    - otherwise cnt[i]++.
  - If sync[i]!=stable[i] and tick=0: cnt[i] holds.
  - cnt width is clog2(STABLE_TICKS), minimum 1 bit. It cannot overflow, because a flip clears it.
  - Any bounce (sync returning to stable) restarts qualification from zero.
- Latency:
  - data_out flips between (STABLE_TICKS-1)*TICK_DIV+1 and STABLE_TICKS*TICK_DIV clocks after sync first disagrees, provided sync is held steady.
  - Total latency from raw_in adds SYNC_STAGES clocks.
- Output alignment:
  - rise_pulse[i] and changed are registered at the same edge that updates stable[i].
  - They are high during the first cycle data_out shows the new value, for exactly one cycle.
  - A 1->0 flip asserts changed but not rise_pulse.
- Simultaneous events:
  - Channels are independent; several may flip on the same tick.
  - changed is the OR of all flips; rise_pulse has one bit per rising flip.
- No handshake: data_out is a continuous level, and downstream samples it every cycle.

Optional Feature:
- Macro PB_LATCH_EN.
- Defined:
  - data_out[i] is sticky: set on rise_pulse[i], cleared only by clear=1 (synchronous, one cycle).
  - Falling debounced edges do not clear data_out.
  - If clear and rise_pulse[i] occur in the same cycle, set wins for that bit.
  - changed asserts on any data_out change, including a clear that drops bits.
  - The debounce core is unchanged.
- Undefined:
  - data_out = stable, and clear is ignored (tie it off; lint waiver).

Decomposition:
- Shared package pb_pkg:
  - PB_WIDTH=8 and default values for SYNC_STAGES, TICK_DIV and STABLE_TICKS;
  - a function computing counter width as clog2 with a minimum of 1.
- Sub-module pb_debounce_chan:
  - one synchroniser plus counter plus stable flop, with inputs tick and raw and outputs level and rise;
  - instantiated WIDTH times via generate.
- Prescaler and output/latch logic stay in the top.

Test Plan:
- Use TICK_DIV=4, STABLE_TICKS=3, SYNC_STAGES=2.
- Reset: drive raw_in=8'hFF while rst_n=0 -> data_out=0, rise_pulse=0, changed=0; after release, data_out=8'hFF within 2+12 clocks and not before 2+9 clocks.
- Clean press: raw_in 0->8'h10 held -> data_out=8'h10 within 11–14 clocks; rise_pulse=8'h10 and changed=1 for exactly one cycle, in the same cycle data_out updates.
- Bounce: toggle raw_in[3] every 5 clocks for 60 clocks, then hold 1 -> data_out[3] stays 0 throughout the bounce and goes 1 only ≥11 clocks after the final hold begins.
- Simultaneous: raw_in 8'h00->8'h81 on one edge -> both bits flip on the same cycle, rise_pulse=8'h81, a single changed pulse.
- Release: data_out=8'h04, raw_in->0 -> data_out=0 after qualification, changed=1, rise_pulse=0.
- With PB_LATCH_EN: press and release bit 2 -> data_out holds 8'h04; assert clear for one cycle -> data_out=0 next cycle with changed=1; assert clear in the same cycle as rise_pulse[5] -> bit 5 stays set.
